irr_sync_capture: RTL and testbench

Parametrised interrupt request register for the 8259-style PIC: captures NUM_IRQ asynchronous request lines through synchronisers and stores them with per-channel edge or level triggering. It supports freeze-with-buffering during acknowledge cycles and presents a masked, rotating-priority winner to the priority resolver and in-service logic. It replaces the fixed 8-bit combinational IRR.

---
 rtl/irr_sync_capture_pkg.sv | 50 +++++
 rtl/irr_sync_capture_sync.sv | 31 +++
 rtl/irr_sync_capture.sv | 138 +++++++++++++
 tb/tb_irr_sync_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/irr_sync_capture_pkg.sv
// -----------------------------------------------------------------------------
// irr_sync_capture_pkg
// Shared constants and helpers for the interrupt request register:
//   TRIG_EDGE / TRIG_LEVEL : trig_mode bit encodings
//   MAX_IRQ / MAX_ID_W     : widest supported channel count / index width
//   win_t                  : result of the rotating-priority scan
//   rot_scan()             : first set bit of a vector, scanning upward from a
//                            base index with wrap-around
// -----------------------------------------------------------------------------
package irr_sync_capture_pkg;

  localparam logic TRIG_EDGE  = 1'b0;
  localparam logic TRIG_LEVEL = 1'b1;

  localparam int MAX_IRQ  = 32;
  localparam int MAX_ID_W = 5;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } win_t;

  // Scan vec[0..n-1] starting at base, increasing index modulo n. An
  // out-of-range base restarts the scan at channel 0.
  function automatic win_t rot_scan(input logic [MAX_IRQ-1:0] vec,
                                    input int unsigned        base,
                                    input int unsigned        n);
    win_t        res;
    int unsigned start;
    int unsigned idx;
    res   = '0;
    start = (base >= n) ? 32'd0 : base;
    for (int k = 0; k < MAX_IRQ; k++) begin
      idx = start + int'(k);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (!res.valid && (int'(k) < n) && vec[idx[MAX_ID_W-1:0]]) begin
        res.valid = 1'b1;
        res.id    = idx[MAX_ID_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irr_sync_capture_sync.sv
// -----------------------------------------------------------------------------
// irr_sync_capture_sync
// Single-bit multi-flop synchroniser for one asynchronous request line.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (chain cleared to 0)
//   i_d     : asynchronous input
//   o_q     : synchronised output (last stage)
// -----------------------------------------------------------------------------
module irr_sync_capture_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/irr_sync_capture.sv
// -----------------------------------------------------------------------------
// irr_sync_capture
// Interrupt request register for an 8259-style PIC with per-channel edge or
// level triggering, edge buffering while frozen, and a masked rotating-
// priority winner.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_irq_in        : raw asynchronous request lines
//   i_trig_mode     : per channel 1 = level, 0 = rising edge
//   i_clear_irr     : one-cycle clear pulses from acknowledge logic
//   i_imr           : mask, 1 = excluded from int_req / winner
//   i_freeze        : blocks IRR sets during the acknowledge sequence
//   i_prio_base     : highest-priority channel (>= NUM_IRQ treated as 0)
//   o_irr_out       : registered IRR
//   o_int_req       : any unmasked pending bit
//   o_win_id        : highest-priority unmasked pending channel (0 if none)
//   o_win_valid     : same as o_int_req
// -----------------------------------------------------------------------------
module irr_sync_capture
  import irr_sync_capture_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_IRQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [NUM_IRQ-1:0] i_trig_mode,
  input  logic [NUM_IRQ-1:0] i_clear_irr,
  input  logic [NUM_IRQ-1:0] i_imr,
  input  logic               i_freeze,
  input  logic [ID_W-1:0]    i_prio_base,
  output logic [NUM_IRQ-1:0] o_irr_out,
  output logic               o_int_req,
  output logic [ID_W-1:0]    o_win_id,
  output logic               o_win_valid
);

  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_irr_next;
  logic [NUM_IRQ-1:0] w_pend_next;
  logic [NUM_IRQ-1:0] w_masked;
  logic [MAX_IRQ-1:0] w_masked_ext;
  win_t               w_win;
  logic               w_unused_id;

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_edge_pend;
  logic [NUM_IRQ-1:0] r_irr;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_sync
      irr_sync_capture_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_irq_in[g]),
        .o_q    (w_sync[g])
      );
    end
  endgenerate

  // prev tracks the synchronised line in every mode, so a line that is
  // already high when a channel switches to edge mode produces no rise.
  assign w_rise = w_sync & ~r_prev;

  // Next IRR and edge-pending state per channel.
  always_comb begin
    w_irr_next  = r_irr;
    w_pend_next = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      case (i_trig_mode[i])
        TRIG_EDGE: begin
          if (i_freeze) begin
            // Clears still act; new edges are parked until freeze drops.
            w_irr_next[i]  = r_irr[i] & ~i_clear_irr[i];
            w_pend_next[i] = r_edge_pend[i] | w_rise[i];
          end else begin
            // A set coinciding with a clear wins.
            w_irr_next[i]  = w_rise[i] | r_edge_pend[i] | (r_irr[i] & ~i_clear_irr[i]);
            w_pend_next[i] = 1'b0;
          end
        end
        TRIG_LEVEL: begin
          // Level channels never buffer, which also flushes any pending
          // edge when a channel is switched from edge to level.
          if (i_freeze) begin
            w_irr_next[i] = r_irr[i] & ~i_clear_irr[i];
          end else begin
            w_irr_next[i] = w_sync[i] & ~i_clear_irr[i];
          end
          w_pend_next[i] = 1'b0;
        end
        default: begin
          w_irr_next[i]  = 1'b0;
          w_pend_next[i] = 1'b0;
        end
      endcase
    end
  end

  // IRR, edge-pending and previous-sample registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev      <= '0;
      r_edge_pend <= '0;
      r_irr       <= '0;
    end else begin
      r_prev      <= w_sync;
      r_edge_pend <= w_pend_next;
      r_irr       <= w_irr_next;
    end
  end

  // Masked rotating-priority winner, combinational from the registered IRR.
  always_comb begin
    w_masked                   = r_irr & ~i_imr;
    w_masked_ext               = '0;
    w_masked_ext[NUM_IRQ-1:0]  = w_masked;
    w_win = rot_scan(w_masked_ext, int'(i_prio_base), int'(NUM_IRQ));
    if (w_win.valid) begin
      o_win_id = w_win.id[ID_W-1:0];
    end else begin
      o_win_id = '0;
    end
    o_int_req   = |w_masked;
    o_win_valid = |w_masked;
  end

  // Upper index bits are always zero for narrower configurations.
  assign w_unused_id = ^w_win.id;

  assign o_irr_out = r_irr;

endmodule

// File: tb/tb_irr_sync_capture.sv
module tb_irr_sync_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 8 channels, 2 stages
  logic [7:0]  a_irq, a_trig, a_clr, a_imr, a_irr;
  logic        a_frz, a_req, a_val;
  logic [2:0]  a_base, a_id;
  // DUT B: 16 channels, 3 stages
  logic [15:0] b_irq, b_irr;
  logic        b_req, b_val;
  logic [3:0]  b_base, b_id;
  // DUT C: 5 channels (prio_base can exceed NUM_IRQ-1)
  logic [4:0]  c_irq, c_irr;
  logic        c_req, c_val;
  logic [2:0]  c_base, c_id;

  irr_sync_capture #(.NUM_IRQ(8), .SYNC_STAGES(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(a_irq), .i_trig_mode(a_trig),
    .i_clear_irr(a_clr), .i_imr(a_imr), .i_freeze(a_frz), .i_prio_base(a_base),
    .o_irr_out(a_irr), .o_int_req(a_req), .o_win_id(a_id), .o_win_valid(a_val));

  irr_sync_capture #(.NUM_IRQ(16), .SYNC_STAGES(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(b_irq), .i_trig_mode(16'h0000),
    .i_clear_irr(16'h0000), .i_imr(16'h0000), .i_freeze(1'b0), .i_prio_base(b_base),
    .o_irr_out(b_irr), .o_int_req(b_req), .o_win_id(b_id), .o_win_valid(b_val));

  irr_sync_capture #(.NUM_IRQ(5), .SYNC_STAGES(2)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(c_irq), .i_trig_mode(5'b00000),
    .i_clear_irr(5'b00000), .i_imr(5'b00000), .i_freeze(1'b0), .i_prio_base(c_base),
    .o_irr_out(c_irr), .o_int_req(c_req), .o_win_id(c_id), .o_win_valid(c_val));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    a_irq = 8'hFF; a_trig = 8'h00; a_clr = 8'h00; a_imr = 8'h00;
    a_frz = 1'b0;  a_base = 3'd0;
    b_irq = 16'h0000; b_base = 4'd0;
    c_irq = 5'b00000; c_base = 3'd0;

    // Reset with all lines high
    tick(3);
    check_eq("rst_irr",   32'(a_irr), 32'h0);
    check_eq("rst_req",   32'(a_req), 32'h0);
    check_eq("rst_val",   32'(a_val), 32'h0);
    check_eq("rst_id",    32'(a_id),  32'h0);
    rst_n = 1'b1;
    tick(2);
    check_eq("rel_2clk",  32'(a_irr), 32'h00);
    tick(1);
    check_eq("rel_3clk",  32'(a_irr), 32'hFF);
    check_eq("rel_req",   32'(a_req), 32'h1);
    check_eq("rel_id",    32'(a_id),  32'h0);

    a_irq = 8'h00; a_clr = 8'hFF;
    tick(1);
    check_eq("clr_all",   32'(a_irr), 32'h00);
    a_clr = 8'h00;
    tick(3);

    // Edge set / clear collision on channel 1
    a_irq[1] = 1'b1;
    tick(3);
    check_eq("e1_set",    32'(a_irr), 32'h02);
    a_irq[1] = 1'b0;
    tick(3);
    check_eq("e1_latch",  32'(a_irr), 32'h02);
    a_irq[1] = 1'b1;
    tick(2);
    a_clr = 8'h02;
    tick(1);
    check_eq("e1_collide", 32'(a_irr), 32'h02);
    tick(1);
    check_eq("e1_clear",  32'(a_irr), 32'h00);
    a_clr = 8'h00; a_irq[1] = 1'b0;
    tick(3);

    // Level re-assert on channel 4
    a_trig[4] = 1'b1; a_irq[4] = 1'b1;
    tick(3);
    check_eq("lv_set",    32'(a_irr), 32'h10);
    a_clr = 8'h10;
    tick(1);
    check_eq("lv_clr",    32'(a_irr), 32'h00);
    a_clr = 8'h00;
    tick(1);
    check_eq("lv_reassert", 32'(a_irr), 32'h10);
    a_irq[4] = 1'b0;
    tick(2);
    check_eq("lv_drop_2", 32'(a_irr), 32'h10);
    tick(1);
    check_eq("lv_drop_3", 32'(a_irr), 32'h00);

    // Switch a high level channel to edge: no spurious set
    a_irq[4] = 1'b1;
    tick(3);
    check_eq("sw_level",  32'(a_irr), 32'h10);
    a_trig[4] = 1'b0; a_clr = 8'h10;
    tick(1);
    a_clr = 8'h00;
    tick(2);
    check_eq("sw_noset",  32'(a_irr), 32'h00);
    a_irq[4] = 1'b0;
    tick(3);

    // Freeze buffering on channel 7
    a_frz = 1'b1; a_irq[7] = 1'b1;
    tick(3);
    check_eq("frz_hold3", 32'(a_irr), 32'h00);
    tick(2);
    check_eq("frz_hold5", 32'(a_irr), 32'h00);
    a_frz = 1'b0;
    tick(1);
    check_eq("frz_rel",   32'(a_irr), 32'h80);
    a_imr = 8'h80; #1;
    check_eq("mask_req",  32'(a_req), 32'h0);
    check_eq("mask_val",  32'(a_val), 32'h0);
    check_eq("mask_irr",  32'(a_irr), 32'h80);
    a_imr = 8'h00;

    // Rotating priority with irr = 1001_0010
    a_irq[1] = 1'b1; a_irq[4] = 1'b1;
    tick(3);
    check_eq("pr_irr",    32'(a_irr), 32'h92);
    a_base = 3'd5; #1;
    check_eq("pr_b5",     32'(a_id),  32'd7);
    a_base = 3'd0; #1;
    check_eq("pr_b0",     32'(a_id),  32'd1);
    a_imr = 8'h82; #1;
    check_eq("pr_m82",    32'(a_id),  32'd4);
    check_eq("pr_m82_val", 32'(a_val), 32'h1);
    a_imr = 8'h80; a_base = 3'd5; #1;
    check_eq("pr_wrap",   32'(a_id),  32'd1);
    a_imr = 8'hFF; #1;
    check_eq("pr_none_id",  32'(a_id),  32'd0);
    check_eq("pr_none_req", 32'(a_req), 32'h0);
    check_eq("pr_none_val", 32'(a_val), 32'h0);

    // 16 channels, 3 stages
    b_irq[15] = 1'b1; b_base = 4'd15;
    tick(3);
    check_eq("b_3clk",    32'(b_irr), 32'h0000);
    tick(1);
    check_eq("b_4clk",    32'(b_irr), 32'h8000);
    check_eq("b_id15",    32'(b_id),  32'd15);
    check_eq("b_val",     32'(b_val), 32'h1);
    b_irq[3] = 1'b1;
    tick(4);
    b_base = 4'd4; #1;
    check_eq("b_b4",      32'(b_id),  32'd15);
    b_base = 4'd0; #1;
    check_eq("b_b0",      32'(b_id),  32'd3);

    // 5 channels: out-of-range base acts as 0
    c_irq = 5'b01010;
    tick(3);
    check_eq("c_irr",     32'(c_irr), 32'h0A);
    c_base = 3'd6; #1;
    check_eq("c_b6",      32'(c_id),  32'd1);
    c_base = 3'd2; #1;
    check_eq("c_b2",      32'(c_id),  32'd3);
    c_base = 3'd4; #1;
    check_eq("c_b4",      32'(c_id),  32'd1);
    c_base = 3'd5; #1;
    check_eq("c_b5",      32'(c_id),  32'd1);

    // Asynchronous reset mid-operation
    rst_n = 1'b0; #1;
    check_eq("arst_a",    32'(a_irr), 32'h00);
    check_eq("arst_b",    32'(b_irr), 32'h0000);
    check_eq("arst_breq", 32'(b_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
